mem_arbiter_n: RTL and testbench

Parametrised N-channel line-memory arbiter placed between the L1 caches (instruction, data, and any future requesters such as a page-table walker or DMA) and the MMU's virtual line port. It serialises one outstanding line read or write at a time onto the single downstream port. It routes the returned line, page-table entry and page-fault indication back to the granted channel only. It supersedes the fixed two-port cache arbiter with configurable channel count, address/line/PTE widths and selectable fairness.

---
 rtl/mem_arbiter_n.sv | 206 ++++++++++++++++++++
 tb/tb_mem_arbiter_n.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-channel line-memory arbiter between L1 requesters and the
// MMU virtual line port. One transaction is outstanding at a time; the reply
// (line, PTE, ack or page fault) is routed back to the granted channel only.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin fairness; when it is
// undefined the lowest requesting index wins (fixed priority).
module mem_arbiter_n #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int PTE_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [N_CH*LINE_W-1:0]   ch_data_i,
  input  logic [N_CH-1:0]          ch_rd_i,
  input  logic [N_CH-1:0]          ch_we_i,
  output logic [LINE_W-1:0]        ch_data_o,
  output logic [PTE_W-1:0]         ch_page_ent_o,
  output logic [N_CH-1:0]          ch_ack_o,
  output logic [N_CH-1:0]          ch_hw_page_fault_o,
  output logic [ADDR_W-1:0]        addr_o,
  output logic [LINE_W-1:0]        data_o,
  output logic                     rd_o,
  output logic                     we_o,
  input  logic [LINE_W-1:0]        data_i,
  input  logic [PTE_W-1:0]         page_ent_i,
  input  logic                     ack_i,
  input  logic                     hw_page_fault_i,
  output logic [N_CH-1:0]          grant_o,
  output logic                     busy_o
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                we_q, we_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [PTE_W-1:0]    pte_q, pte_d;
  logic [N_CH-1:0]     ack_q, ack_d;
  logic [N_CH-1:0]     fault_q, fault_d;
  logic [N_CH-1:0]     grant_q, grant_d;
  logic                busy_q, busy_d;

  logic [N_CH-1:0]     req;
  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;
  logic [N_CH-1:0]     win_oh;

  assign req    = ch_rd_i | ch_we_i;
  assign win_oh = {{(N_CH-1){1'b0}}, 1'b1} << win_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  int                  cand;
  logic [IDX_W-1:0]    cidx;

  // Round-robin pick: scan from the channel after the last grant, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    cidx    = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = int'(ptr_q) + 1 + i;
      if (cand >= N_CH) cand = cand - N_CH;
      cidx = IDX_W'(cand);
      if (!win_vld && req[cidx]) begin
        win_vld = 1'b1;
        win_idx = cidx;
      end
    end
  end

  // Pointer remembers the most recent grant so it gets lowest priority next.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && win_vld) ptr_d = win_idx;
  end

  // Pointer register; reset value makes channel 0 the first candidate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= IDX_W'(N_CH - 1);
    else      ptr_q <= ptr_d;
  end
`else
  logic [IDX_W-1:0]    cidx;

  // Fixed priority pick: lowest requesting index wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cidx    = '0;
    for (int i = 0; i < N_CH; i++) begin
      cidx = IDX_W'(i);
      if (!win_vld && req[cidx]) begin
        win_vld = 1'b1;
        win_idx = cidx;
      end
    end
  end
`endif

  // Next-state and next-output computation for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    pte_d   = pte_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    ack_d   = '0;
    fault_d = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          addr_d  = ch_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d = ch_data_i[int'(win_idx)*LINE_W +: LINE_W];
          // A channel raising both strobes is serviced as a write.
          we_d    = ch_we_i[win_idx];
          rd_d    = ch_rd_i[win_idx] & ~ch_we_i[win_idx];
          grant_d = win_oh;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ack_i || hw_page_fault_i) begin
          rdata_d = data_i;
          pte_d   = page_ent_i;
          rd_d    = 1'b0;
          we_d    = 1'b0;
          // A fault takes precedence over a simultaneous ack.
          if (hw_page_fault_i) fault_d = grant_q;
          else                 ack_d   = grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        rd_d    = 1'b0;
        we_d    = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and all outputs are registered; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      pte_q   <= '0;
      ack_q   <= '0;
      fault_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      pte_q   <= pte_d;
      ack_q   <= ack_d;
      fault_q <= fault_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign addr_o             = addr_q;
  assign data_o             = wdata_q;
  assign rd_o               = rd_q;
  assign we_o               = we_q;
  assign ch_data_o          = rdata_q;
  assign ch_page_ent_o      = pte_q;
  assign ch_ack_o           = ack_q;
  assign ch_hw_page_fault_o = fault_q;
  assign grant_o            = grant_q;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed testbench for mem_arbiter_n with four channels.
// Expectations follow ARB_ROUND_ROBIN_EN if it is defined for the build.
module tb_mem_arbiter_n;

  localparam int N_CH   = 4;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int PTE_W  = 32;

  logic                   clk;
  logic                   rst;
  logic [N_CH*ADDR_W-1:0] ch_addr_i;
  logic [N_CH*LINE_W-1:0] ch_data_i;
  logic [N_CH-1:0]        ch_rd_i;
  logic [N_CH-1:0]        ch_we_i;
  logic [LINE_W-1:0]      ch_data_o;
  logic [PTE_W-1:0]       ch_page_ent_o;
  logic [N_CH-1:0]        ch_ack_o;
  logic [N_CH-1:0]        ch_hw_page_fault_o;
  logic [ADDR_W-1:0]      addr_o;
  logic [LINE_W-1:0]      data_o;
  logic                   rd_o;
  logic                   we_o;
  logic [LINE_W-1:0]      data_i;
  logic [PTE_W-1:0]       page_ent_i;
  logic                   ack_i;
  logic                   hw_page_fault_i;
  logic [N_CH-1:0]        grant_o;
  logic                   busy_o;

  logic ack_man;
  logic auto_ack;
  int   n_cmp;
  int   n_bad;

  // Zero-wait downstream when auto_ack is set, otherwise manually driven ack.
  assign ack_i = ack_man | (auto_ack & (rd_o | we_o));

  mem_arbiter_n #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .PTE_W(PTE_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_addr_i(ch_addr_i), .ch_data_i(ch_data_i),
    .ch_rd_i(ch_rd_i), .ch_we_i(ch_we_i),
    .ch_data_o(ch_data_o), .ch_page_ent_o(ch_page_ent_o),
    .ch_ack_o(ch_ack_o), .ch_hw_page_fault_o(ch_hw_page_fault_o),
    .addr_o(addr_o), .data_o(data_o), .rd_o(rd_o), .we_o(we_o),
    .data_i(data_i), .page_ent_i(page_ent_i),
    .ack_i(ack_i), .hw_page_fault_i(hw_page_fault_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ch_addr_i = '0; ch_data_i = '0; ch_rd_i = '0; ch_we_i = '0;
    data_i = '0; page_ent_i = '0; ack_man = 1'b0; auto_ack = 1'b0;
    hw_page_fault_i = 1'b0;
    tick(); tick();
    n_cmp++; if (grant_o !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got %b want 0000", grant_o); end
    n_cmp++; if ({rd_o, we_o, busy_o} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes got %b want 000", {rd_o, we_o, busy_o}); end
    n_cmp++; if ({ch_ack_o, ch_hw_page_fault_o} !== 8'h00) begin n_bad++; $display("FAIL reset_pulses got %h want 00", {ch_ack_o, ch_hw_page_fault_o}); end
    n_cmp++; if (addr_o !== 32'h0 || ch_page_ent_o !== 32'h0) begin n_bad++; $display("FAIL reset_addr_pte got %h/%h want 0/0", addr_o, ch_page_ent_o); end
    rst = 1'b1;
    tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got %b want 0", busy_o); end
  endtask

  task automatic test_single_read();
    ch_addr_i[31:0] = 32'h0000_1000;
    ch_rd_i = 4'b0001;
    tick();
    n_cmp++; if ({rd_o, we_o} !== 2'b10) begin n_bad++; $display("FAIL rd_strobe got %b want 10", {rd_o, we_o}); end
    n_cmp++; if (grant_o !== 4'b0001) begin n_bad++; $display("FAIL rd_grant got %b want 0001", grant_o); end
    n_cmp++; if (addr_o !== 32'h0000_1000) begin n_bad++; $display("FAIL rd_addr got %h want 00001000", addr_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL rd_busy got %b want 1", busy_o); end
    tick();
    n_cmp++; if (ch_ack_o !== 4'b0000) begin n_bad++; $display("FAIL rd_early_ack got %b want 0000", ch_ack_o); end
    tick();
    data_i = {32{8'hA5}};
    page_ent_i = 32'h0000_1007;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    ch_rd_i = 4'b0000;
    n_cmp++; if (ch_ack_o !== 4'b0001) begin n_bad++; $display("FAIL rd_ack got %b want 0001", ch_ack_o); end
    n_cmp++; if (ch_data_o !== {32{8'hA5}}) begin n_bad++; $display("FAIL rd_line got %h want a5..a5", ch_data_o); end
    n_cmp++; if (ch_page_ent_o !== 32'h0000_1007) begin n_bad++; $display("FAIL rd_pte got %h want 00001007", ch_page_ent_o); end
    n_cmp++; if ({rd_o, busy_o} !== 2'b01) begin n_bad++; $display("FAIL rd_done_state got %b want 01", {rd_o, busy_o}); end
    tick();
    n_cmp++; if (ch_ack_o !== 4'b0000) begin n_bad++; $display("FAIL rd_ack_pulse got %b want 0000", ch_ack_o); end
    n_cmp++; if ({grant_o, busy_o} !== 5'b00000) begin n_bad++; $display("FAIL rd_back_idle got %b want 00000", {grant_o, busy_o}); end
    n_cmp++; if (ch_data_o !== {32{8'hA5}}) begin n_bad++; $display("FAIL rd_line_hold got %h want a5..a5", ch_data_o); end
  endtask

  task automatic test_contention();
    int          exp_g [5];
    logic [3:0]  exp_oh;
    logic [31:0] exp_a;
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 2, 3, 0};
`else
    exp_g = '{0, 0, 0, 0, 0};
`endif
    rst = 1'b0;
    #1;
    rst = 1'b1;
    for (int k = 0; k < N_CH; k++) ch_addr_i[k*ADDR_W +: ADDR_W] = 32'h2000 + k;
    auto_ack = 1'b1;
    ch_rd_i = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_oh = 4'b0001 << exp_g[t];
      exp_a  = 32'h2000 + exp_g[t];
      tick();
      n_cmp++; if (grant_o !== exp_oh) begin n_bad++; $display("FAIL cont_grant%0d got %b want %b", t, grant_o, exp_oh); end
      n_cmp++; if (addr_o !== exp_a) begin n_bad++; $display("FAIL cont_addr%0d got %h want %h", t, addr_o, exp_a); end
      tick();
      n_cmp++; if (ch_ack_o !== exp_oh) begin n_bad++; $display("FAIL cont_ack%0d got %b want %b", t, ch_ack_o, exp_oh); end
      if (t == 4) ch_rd_i = 4'b0000;
      tick();
      n_cmp++; if ({grant_o, busy_o} !== 5'b00000) begin n_bad++; $display("FAIL cont_idle%0d got %b want 00000", t, {grant_o, busy_o}); end
    end
    auto_ack = 1'b0;
  endtask

  task automatic test_page_fault();
    ch_rd_i = 4'b0010;
    tick();
    n_cmp++; if ({grant_o, rd_o} !== 5'b00101) begin n_bad++; $display("FAIL pf_grant got %b want 00101", {grant_o, rd_o}); end
    data_i = {32{8'h3C}};
    page_ent_i = 32'h0000_FA17;
    ack_man = 1'b1;
    hw_page_fault_i = 1'b1;
    tick();
    ack_man = 1'b0;
    hw_page_fault_i = 1'b0;
    ch_rd_i = 4'b0000;
    n_cmp++; if (ch_hw_page_fault_o !== 4'b0010) begin n_bad++; $display("FAIL pf_fault got %b want 0010", ch_hw_page_fault_o); end
    n_cmp++; if (ch_ack_o !== 4'b0000) begin n_bad++; $display("FAIL pf_no_ack got %b want 0000", ch_ack_o); end
    n_cmp++; if (ch_page_ent_o !== 32'h0000_FA17) begin n_bad++; $display("FAIL pf_pte got %h want 0000fa17", ch_page_ent_o); end
    tick();
    n_cmp++; if ({busy_o, grant_o, ch_hw_page_fault_o} !== 9'h000) begin n_bad++; $display("FAIL pf_back_idle got %b want 0", {busy_o, grant_o, ch_hw_page_fault_o}); end
  endtask

  task automatic test_rd_we_both();
    ch_data_i[LINE_W-1:0] = 256'hDEAD;
    ch_rd_i = 4'b0001;
    ch_we_i = 4'b0001;
    tick();
    n_cmp++; if ({we_o, rd_o} !== 2'b10) begin n_bad++; $display("FAIL rw_type got we,rd=%b want 10", {we_o, rd_o}); end
    n_cmp++; if (data_o !== 256'hDEAD) begin n_bad++; $display("FAIL rw_line got %h want ..dead", data_o); end
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    ch_rd_i = 4'b0000;
    ch_we_i = 4'b0000;
    n_cmp++; if ({ch_ack_o, we_o} !== 5'b00010) begin n_bad++; $display("FAIL rw_ack got %b want 00010", {ch_ack_o, we_o}); end
    tick();
  endtask

  task automatic test_drop_mid_busy();
    ch_addr_i[31:0] = 32'h0000_3000;
    ch_rd_i = 4'b0001;
    tick();
    ch_rd_i = 4'b0000;
    ch_addr_i[31:0] = 32'h0000_4444;
    tick();
    n_cmp++; if ({rd_o, grant_o} !== 5'b10001) begin n_bad++; $display("FAIL drop_hold got %b want 10001", {rd_o, grant_o}); end
    n_cmp++; if (addr_o !== 32'h0000_3000) begin n_bad++; $display("FAIL drop_addr got %h want 00003000", addr_o); end
    tick();
    n_cmp++; if (rd_o !== 1'b1) begin n_bad++; $display("FAIL drop_hold2 got %b want 1", rd_o); end
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    n_cmp++; if ({rd_o, ch_ack_o} !== 5'b00001) begin n_bad++; $display("FAIL drop_ack got %b want 00001", {rd_o, ch_ack_o}); end
    tick();
  endtask

  task automatic test_async_reset_mid_busy();
    ch_data_i[2*LINE_W +: LINE_W] = {32{8'h5A}};
    ch_addr_i[2*ADDR_W +: ADDR_W] = 32'h0000_7000;
    ch_rd_i = 4'b0100;
    tick();
    n_cmp++; if ({grant_o, rd_o} !== 5'b01001) begin n_bad++; $display("FAIL ar_grant got %b want 01001", {grant_o, rd_o}); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if ({rd_o, we_o, busy_o, grant_o} !== 7'b0) begin n_bad++; $display("FAIL ar_ctrl got %b want 0", {rd_o, we_o, busy_o, grant_o}); end
    n_cmp++; if (addr_o !== 32'h0 || data_o !== '0) begin n_bad++; $display("FAIL ar_down got %h want 0", addr_o); end
    n_cmp++; if (ch_data_o !== '0 || ch_page_ent_o !== 32'h0) begin n_bad++; $display("FAIL ar_reply got %h want 0", ch_page_ent_o); end
    n_cmp++; if ({ch_ack_o, ch_hw_page_fault_o} !== 8'h00) begin n_bad++; $display("FAIL ar_pulses got %h want 00", {ch_ack_o, ch_hw_page_fault_o}); end
    ch_rd_i = 4'b1101;
    rst = 1'b1;
    tick();
    n_cmp++; if (grant_o !== 4'b0001) begin n_bad++; $display("FAIL ar_first_grant got %b want 0001", grant_o); end
    ch_rd_i = 4'b0000;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_page_fault();
    test_rd_we_both();
    test_drop_mid_busy();
    test_async_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
